// File: rtl/bram_ctrl_pkg.sv
// Shared types and constants for the BRAM accessor control path.
package bram_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } sched_state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_ABORT   = 2'b10;

    localparam int unsigned MEM_SIZE_DEFAULT = 256;

endpackage

// File: rtl/bram_run_watchdog.sv
// Per-run watchdog: counts enabled cycles since the last clear.
// o_expire flags the cycle that is the i_timeout-th enabled one.
module bram_run_watchdog #(
    parameter int TO_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clear,
    input  logic            i_enable,
    input  logic [TO_W-1:0] i_timeout,
    output logic            o_expire
);

    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != '1)) begin
            r_cnt <= r_cnt + TO_W'(1);
        end
    end

    assign o_expire = i_enable && (i_timeout != '0) && (r_cnt == i_timeout - TO_W'(1));

endmodule

// File: rtl/bram_run_scheduler.sv
// Splits a job into accessor runs of at most one chunk, with watchdog,
// abort and completion reporting.
module bram_run_scheduler
    import bram_ctrl_pkg::*;
#(
    parameter int CNT_BIT  = 31,
    parameter int MEM_SIZE = MEM_SIZE_DEFAULT,
    parameter int TO_W     = 16,
    parameter int IDX_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               job_valid_i,
    output logic               job_ready_o,
    input  logic [CNT_BIT-1:0] job_total_i,
    input  logic [CNT_BIT-1:0] job_chunk_i,
    input  logic [TO_W-1:0]    timeout_i,
    input  logic               abort_i,
    input  logic               acc_idle_i,
    input  logic               acc_done_i,
    output logic               start_run_o,
    output logic [CNT_BIT-1:0] run_count_o,
    output logic               busy_o,
    output logic [IDX_W-1:0]   run_idx_o,
    output logic [CNT_BIT-1:0] remaining_o,
    output logic               job_done_o,
    output logic [1:0]         err_code_o
);

    localparam logic [CNT_BIT-1:0] LP_MEM = CNT_BIT'(MEM_SIZE);

    sched_state_t       r_state, w_state_nxt;
    logic [CNT_BIT-1:0] r_remaining, w_remaining_nxt;
    logic [CNT_BIT-1:0] r_chunk, w_chunk_nxt;
    logic [CNT_BIT-1:0] r_run_count, w_run_count_nxt;
    logic [IDX_W-1:0]   r_run_idx, w_run_idx_nxt;
    logic [1:0]         r_err, w_err_nxt;
    logic               r_start, w_start_nxt;
    logic [CNT_BIT-1:0] w_job_chunk;
    logic [CNT_BIT-1:0] w_issue_cnt;
    logic [CNT_BIT-1:0] w_rem_after;
    logic               w_wd_expire;

    assign w_job_chunk = ((job_chunk_i == '0) || (job_chunk_i > LP_MEM)) ? LP_MEM : job_chunk_i;
    // remaining only moves on done, so the issued length can be recomputed in WAIT
    assign w_issue_cnt = (r_chunk < r_remaining) ? r_chunk : r_remaining;
    assign w_rem_after = r_remaining - w_issue_cnt;

    bram_run_watchdog #(
        .TO_W (TO_W)
    ) u_watchdog (
        .clk       (clk),
        .rst       (reset),
        .i_clear   (w_start_nxt),
        .i_enable  (r_state == S_WAIT),
        .i_timeout (timeout_i),
        .o_expire  (w_wd_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_chunk     <= '0;
            r_run_count <= '0;
            r_run_idx   <= '0;
            r_err       <= ERR_OK;
            r_start     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_chunk     <= w_chunk_nxt;
            r_run_count <= w_run_count_nxt;
            r_run_idx   <= w_run_idx_nxt;
            r_err       <= w_err_nxt;
            r_start     <= w_start_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_chunk_nxt     = r_chunk;
        w_run_count_nxt = '0;
        w_run_idx_nxt   = r_run_idx;
        w_err_nxt       = r_err;
        w_start_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (job_valid_i) begin
                    w_remaining_nxt = job_total_i;
                    w_chunk_nxt     = w_job_chunk;
                    w_run_idx_nxt   = '0;
                    w_err_nxt       = ERR_OK;
                    w_state_nxt     = (job_total_i == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (abort_i) begin
                    w_err_nxt   = ERR_ABORT;
                    w_state_nxt = S_DONE;
                end else if (acc_idle_i) begin
                    w_start_nxt     = 1'b1;
                    w_run_count_nxt = w_issue_cnt;
                    w_state_nxt     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (acc_done_i) begin
                    w_remaining_nxt = w_rem_after;
                    w_run_idx_nxt   = (r_run_idx == '1) ? r_run_idx : r_run_idx + IDX_W'(1);
                    // a run that completes the job outranks a coincident abort
                    if (w_rem_after == '0) begin
                        w_state_nxt = S_DONE;
                    end else if (abort_i) begin
                        w_err_nxt   = ERR_ABORT;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_ISSUE;
                    end
                end else if (abort_i) begin
                    w_err_nxt   = ERR_ABORT;
                    w_state_nxt = S_DONE;
                end else if (w_wd_expire) begin
                    w_err_nxt   = ERR_TIMEOUT;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign job_ready_o = (r_state == S_IDLE);
    assign busy_o      = (r_state != S_IDLE);
    assign job_done_o  = (r_state == S_DONE);
    assign start_run_o = r_start;
    assign run_count_o = r_run_count;
    assign run_idx_o   = r_run_idx;
    assign remaining_o = r_remaining;
    assign err_code_o  = r_err;

endmodule

// File: tb/tb_bram_run_scheduler.sv
// Directed bench for bram_run_scheduler; the bench plays the accessor.
module tb_bram_run_scheduler;

    localparam int CNT_BIT = 31;
    localparam int TO_W    = 16;
    localparam int IDX_W   = 16;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               job_valid = 1'b0;
    logic               job_ready;
    logic [CNT_BIT-1:0] job_total = '0;
    logic [CNT_BIT-1:0] job_chunk = '0;
    logic [TO_W-1:0]    timeout = '0;
    logic               abort = 1'b0;
    logic               acc_idle = 1'b1;
    logic               acc_done = 1'b0;
    logic               start_run;
    logic [CNT_BIT-1:0] run_count;
    logic               busy;
    logic [IDX_W-1:0]   run_idx;
    logic [CNT_BIT-1:0] remaining;
    logic               job_done;
    logic [1:0]         err_code;

    int checks = 0;
    int errors = 0;
    int n_starts = 0;
    int idle_viol = 0;
    logic tb_idle_q = 1'b1;

    bram_run_scheduler #(
        .CNT_BIT  (CNT_BIT),
        .MEM_SIZE (256),
        .TO_W     (TO_W),
        .IDX_W    (IDX_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .job_valid_i (job_valid),
        .job_ready_o (job_ready),
        .job_total_i (job_total),
        .job_chunk_i (job_chunk),
        .timeout_i   (timeout),
        .abort_i     (abort),
        .acc_idle_i  (acc_idle),
        .acc_done_i  (acc_done),
        .start_run_o (start_run),
        .run_count_o (run_count),
        .busy_o      (busy),
        .run_idx_o   (run_idx),
        .remaining_o (remaining),
        .job_done_o  (job_done),
        .err_code_o  (err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tb_idle_q <= acc_idle;

    always @(negedge clk) begin
        if (start_run) begin
            n_starts++;
            if (!tb_idle_q) idle_viol++;
        end
    end

    task automatic submit(input logic [CNT_BIT-1:0] total, input logic [CNT_BIT-1:0] chunk);
        @(negedge clk);
        job_valid = 1'b1;
        job_total = total;
        job_chunk = chunk;
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic wait_start(output bit found, output int cyc, output logic [CNT_BIT-1:0] cnt);
        found = 1'b0;
        cyc   = 0;
        cnt   = '0;
        while (!found && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (start_run) begin
                found = 1'b1;
                cnt   = run_count;
            end
        end
    endtask

    task automatic pulse_done();
        acc_done = 1'b1;
        acc_idle = 1'b1;
        @(negedge clk);
        acc_done = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({job_ready, start_run, busy, job_done} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags ready/start/busy/done=%b required 1000", {job_ready, start_run, busy, job_done});
        end
        checks++;
        if (run_count !== '0 || run_idx !== '0 || remaining !== '0 || err_code !== 2'b00) begin
            errors++;
            $display("FAIL reset_values count=%0d idx=%0d rem=%0d err=%b required 0 0 0 00", run_count, run_idx, remaining, err_code);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_run();
        bit found; int cyc; logic [CNT_BIT-1:0] cnt;
        int s0;
        s0 = n_starts;
        submit(256, 256);
        wait_start(found, cyc, cnt);
        checks++;
        if (!found || cyc != 1 || cnt !== 256) begin
            errors++;
            $display("FAIL single_start found=%0d latency=%0d count=%0d required 1 1 256", found, cyc, cnt);
        end
        acc_idle = 1'b0;
        repeat (299) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || job_done !== 1'b0 || run_count !== '0) begin
            errors++;
            $display("FAIL single_wait busy=%b done=%b count=%0d required 1 0 0", busy, job_done, run_count);
        end
        pulse_done();
        checks++;
        if (job_done !== 1'b1 || err_code !== 2'b00 || run_idx !== 1 || remaining !== '0) begin
            errors++;
            $display("FAIL single_done done=%b err=%b idx=%0d rem=%0d required 1 00 1 0", job_done, err_code, run_idx, remaining);
        end
        @(negedge clk);
        checks++;
        if (job_done !== 1'b0 || job_ready !== 1'b1 || busy !== 1'b0 || n_starts - s0 != 1) begin
            errors++;
            $display("FAIL single_idle done=%b ready=%b busy=%b starts=%0d required 0 1 0 1", job_done, job_ready, busy, n_starts - s0);
        end
    endtask

    task automatic test_multi_run();
        bit found; int cyc; logic [CNT_BIT-1:0] cnt;
        logic [CNT_BIT-1:0] exp_cnt [3] = '{256, 256, 88};
        logic [CNT_BIT-1:0] exp_rem [3] = '{344, 88, 0};
        acc_idle = 1'b0;
        submit(600, 0);
        for (int r = 0; r < 3; r++) begin
            acc_idle = 1'b0;
            repeat (3) @(negedge clk);
            acc_idle = 1'b1;
            wait_start(found, cyc, cnt);
            checks++;
            if (!found || cyc != 1 || cnt !== exp_cnt[r]) begin
                errors++;
                $display("FAIL multi_start run=%0d found=%0d latency=%0d count=%0d required 1 1 %0d", r, found, cyc, cnt, exp_cnt[r]);
            end
            acc_idle = 1'b0;
            repeat (4) @(negedge clk);
            acc_done = 1'b1;
            @(negedge clk);
            acc_done = 1'b0;
            checks++;
            if (remaining !== exp_rem[r] || run_idx !== IDX_W'(r + 1)) begin
                errors++;
                $display("FAIL multi_progress run=%0d rem=%0d idx=%0d required %0d %0d", r, remaining, run_idx, exp_rem[r], r + 1);
            end
        end
        checks++;
        if (job_done !== 1'b1 || err_code !== 2'b00) begin
            errors++;
            $display("FAIL multi_done done=%b err=%b required 1 00", job_done, err_code);
        end
        checks++;
        if (idle_viol != 0) begin
            errors++;
            $display("FAIL start_while_busy violations=%0d required 0", idle_viol);
        end
        acc_idle = 1'b1;
    endtask

    task automatic test_zero_total();
        int s0;
        s0 = n_starts;
        submit(0, 17);
        checks++;
        if (job_done !== 1'b1 || err_code !== 2'b00 || job_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_done done=%b err=%b ready=%b required 1 00 0", job_done, err_code, job_ready);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (n_starts != s0 || job_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_nostart starts=%0d done=%b busy=%b required 0 0 0", n_starts - s0, job_done, busy);
        end
    endtask

    task automatic test_timeout();
        bit found; int cyc; logic [CNT_BIT-1:0] cnt;
        int k;
        timeout = 50;
        submit(40, 10);
        wait_start(found, cyc, cnt);
        acc_idle = 1'b0;
        checks++;
        if (!found || cnt !== 10) begin
            errors++;
            $display("FAIL timeout_start found=%0d count=%0d required 1 10", found, cnt);
        end
        k = 0;
        while (k < 100 && !job_done) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k != 50) begin
            errors++;
            $display("FAIL timeout_latency cycles=%0d required 50", k);
        end
        checks++;
        if (err_code !== 2'b01 || remaining !== 40 || run_idx !== '0) begin
            errors++;
            $display("FAIL timeout_report err=%b rem=%0d idx=%0d required 01 40 0", err_code, remaining, run_idx);
        end
        timeout = '0;
        acc_idle = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_abort();
        bit found; int cyc; logic [CNT_BIT-1:0] cnt;
        submit(100, 100);
        wait_start(found, cyc, cnt);
        acc_idle = 1'b0;
        repeat (5) @(negedge clk);
        abort = 1'b1;
        pulse_done();
        abort = 1'b0;
        checks++;
        if (job_done !== 1'b1 || err_code !== 2'b00 || remaining !== '0 || run_idx !== 1) begin
            errors++;
            $display("FAIL abort_final done=%b err=%b rem=%0d idx=%0d required 1 00 0 1", job_done, err_code, remaining, run_idx);
        end
        submit(200, 100);
        wait_start(found, cyc, cnt);
        acc_idle = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (job_done !== 1'b1 || err_code !== 2'b10 || run_idx !== '0 || remaining !== 200) begin
            errors++;
            $display("FAIL abort_first done=%b err=%b idx=%0d rem=%0d required 1 10 0 200", job_done, err_code, run_idx, remaining);
        end
        acc_idle = 1'b1;
        @(negedge clk);
        abort = 1'b1;
        acc_done = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        acc_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || err_code !== 2'b10 || job_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle busy=%b err=%b done=%b required 0 10 0", busy, err_code, job_done);
        end
    endtask

    task automatic test_reset_mid();
        bit found; int cyc; logic [CNT_BIT-1:0] cnt;
        submit(500, 0);
        wait_start(found, cyc, cnt);
        acc_idle = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({job_ready, start_run, busy, job_done} !== 4'b1000 || remaining !== '0 || run_idx !== '0 || err_code !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid flags=%b rem=%0d idx=%0d err=%b required 1000 0 0 00", {job_ready, start_run, busy, job_done}, remaining, run_idx, err_code);
        end
        @(negedge clk);
        reset = 1'b0;
        acc_idle = 1'b1;
        submit(10, 0);
        wait_start(found, cyc, cnt);
        checks++;
        if (!found || cnt !== 10) begin
            errors++;
            $display("FAIL reset_newjob_start found=%0d count=%0d required 1 10", found, cnt);
        end
        acc_idle = 1'b0;
        repeat (2) @(negedge clk);
        pulse_done();
        checks++;
        if (job_done !== 1'b1 || err_code !== 2'b00 || remaining !== '0 || run_idx !== 1) begin
            errors++;
            $display("FAIL reset_newjob_done done=%b err=%b rem=%0d idx=%0d required 1 00 0 1", job_done, err_code, remaining, run_idx);
        end
    endtask

    initial begin
        test_reset();
        test_single_run();
        test_multi_run();
        test_zero_total();
        test_timeout();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
